calc_req_driver: RTL and testbench
==================================

Name: calc_req_driver

Overview:
- Transaction-level front end for one requestor port of the calc design.
- Accepts a whole command (cmd, operand1, operand2) on a valid/ready interface and serialises it onto the two-cycle reqN_cmd_in/reqN_data_in protocol.
- Waits for the matching out_resp/out_data and returns the result on a valid/ready response interface, with timeout.
- One instance per requestor port (4 in the full bench/SoC).

Parameters:
- CMD_W, 4, width of command field.
- DATA_W, 32, width of operand/result data.
- TIMEOUT_CYCLES, 64, max WAIT_RSP cycles before a timeout response; must be >= 2.

Ports:
- c_clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- txn_valid  in  1  transaction offered.
- txn_ready  out  1  driver can accept a transaction.
- txn_cmd  in  CMD_W  command: 1 add, 2 sub, 5 shl, 6 shr; others are passed through to the calc.
- txn_op1  in  DATA_W  operand 1.
- txn_op2  in  DATA_W  operand 2.
- req_cmd_out  out  CMD_W  to calc reqN_cmd_in.
- req_data_out  out  DATA_W  to calc reqN_data_in.
- out_resp  in  2  calc response code for this port (0 = none).
- out_data  in  DATA_W  calc response data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_code  out  2  0 = timeout/no-op, 1 = success, 2 = overflow/underflow, 3 = invalid cmd.
- rsp_data  out  DATA_W  result; 0 on timeout.
- busy  out  1  high in any state other than IDLE.
- protocol_err  out  1  sticky; unexpected out_resp seen.

Behaviour:
- Reset (async assert, sync deassert by c_clk):
  - state = IDLE.
  - req_cmd_out = 0, req_data_out = 0.
  - rsp_valid = 0, rsp_code = 0, rsp_data = 0.
  - busy = 0, protocol_err = 0, timeout counter = 0.
  - All outputs are registered.
- FSM states: IDLE, SEND_OP1, SEND_OP2, WAIT_RSP, HOLD_RSP.
- IDLE:
  - txn_ready = 1.
  - On txn_valid: capture cmd/op1/op2.
  - If cmd != 0, go to SEND_OP1.
  - If cmd == 0, go to HOLD_RSP with rsp_code = 0 and rsp_data = 0; no bus activity.
- SEND_OP1 (exactly 1 cycle): req_cmd_out = cmd, req_data_out = op1.
- SEND_OP2 (exactly 1 cycle): req_cmd_out = 0, req_data_out = op2.
- WAIT_RSP:
  - req_cmd_out = 0, req_data_out = 0.
  - Counter clears on entry and increments each cycle.
  - First cycle with out_resp != 0: capture out_resp/out_data into rsp_code/rsp_data, go to HOLD_RSP.
  - If the counter reaches TIMEOUT_CYCLES-1 with out_resp == 0: rsp_code = 0, rsp_data = 0, go to HOLD_RSP.
  - A response in the same cycle as the timeout wins over the timeout.
- HOLD_RSP:
  - rsp_valid = 1; rsp_code/rsp_data held stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE next cycle.
  - No txn accepted in the same cycle (1 idle bubble between transactions).
- Latency: txn accept at cycle T gives op1 on the bus at T+1, op2 at T+2. The earliest rsp_valid is the cycle after out_resp is sampled.
- txn_ready = 0 in every state except IDLE.
- Unexpected response: out_resp != 0 in any state other than WAIT_RSP sets protocol_err (sticky until reset). The data is discarded and there is no state change.
- Reset mid-operation returns the block to IDLE immediately:
  - The bus goes to 0.
  - The pending transaction and any held response are dropped.
- Widths and data: data is passed through unmodified, and the driver does no arithmetic. The counter width is clog2(TIMEOUT_CYCLES).

Decomposition:
- Package calc_pkg holds:
  - CMD_W and DATA_W.
  - Command constants CMD_NOP=0, CMD_ADD=1, CMD_SUB=2, CMD_SHL=5, CMD_SHR=6.
  - Response constants RSP_NONE=0, RSP_OK=1, RSP_OVF=2, RSP_INV=3.
  - The FSM state enum.
- No sub-module is needed. The timeout counter is inline.
- A top-level calc_req_driver_x4 wrapper instantiating four drivers is a separate block.

Test Plan:
- Add: txn cmd=1, op1=0x00000001, op2=0x01FFFFFF.
  - Bus shows cmd 1/data 0x1, then cmd 0/data 0x01FFFFFF.
  - Model returns resp 1, data 0x02000000 after 3 cycles.
  - rsp_code=1, rsp_data=0x02000000, rsp_valid one cycle after.
- Overflow: op1=op2=0xFFFFFFFF with cmd 1.
  - Model returns resp 2 → rsp_code=2.
  - Then cmd 2 with op1=0xFFFFFFFF, op2=0x1, model resp 1 data 0xFFFFFFFE → rsp_code=1, rsp_data=0xFFFFFFFE.
- Timeout: TIMEOUT_CYCLES=8, no out_resp → rsp_code=0, rsp_data=0 exactly 8 WAIT cycles after SEND_OP2.
  - Repeat with resp arriving on the 8th cycle → rsp_code=resp (response wins).
- Backpressure and unexpected response: hold rsp_ready=0 for 5 cycles.
  - rsp fields stay stable, txn_ready=0, and a second txn_valid is not accepted.
  - Inject out_resp=1 during HOLD → protocol_err=1, rsp unchanged.
- Reset mid-WAIT_RSP: assert reset asynchronously (no clock edge).
  - All outputs go to 0 immediately.
  - After release the block is in IDLE with txn_ready=1, and a stale out_resp is not reported.
- No-op and back-to-back: cmd 0 → rsp_code=0 with no bus activity.
  - Two valid txns offered continuously → second accepted only after the first response handshake plus one idle cycle.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared widths, command/response codes and driver FSM states for the calc requestor front end.
package calc_pkg;

   localparam int CMD_W  = 4;
   localparam int DATA_W = 32;

   localparam logic [3:0] CMD_NOP = 4'd0;
   localparam logic [3:0] CMD_ADD = 4'd1;
   localparam logic [3:0] CMD_SUB = 4'd2;
   localparam logic [3:0] CMD_SHL = 4'd5;
   localparam logic [3:0] CMD_SHR = 4'd6;

   localparam logic [1:0] RSP_NONE = 2'd0;
   localparam logic [1:0] RSP_OK   = 2'd1;
   localparam logic [1:0] RSP_OVF  = 2'd2;
   localparam logic [1:0] RSP_INV  = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND_OP1,
      ST_SEND_OP2,
      ST_WAIT_RSP,
      ST_HOLD_RSP
   } state_t;

endpackage

// File: rtl/calc_req_driver.sv
// Serialises one (cmd, op1, op2) transaction onto the two-cycle calc request bus
// and returns the calc response (or a timeout) on a valid/ready interface.
module calc_req_driver
   import calc_pkg::*;
#(
   parameter int CMD_W          = calc_pkg::CMD_W,
   parameter int DATA_W         = calc_pkg::DATA_W,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              c_clk,
   input  logic              reset,
   input  logic              txn_valid,
   output logic              txn_ready,
   input  logic [CMD_W-1:0]  txn_cmd,
   input  logic [DATA_W-1:0] txn_op1,
   input  logic [DATA_W-1:0] txn_op2,
   output logic [CMD_W-1:0]  req_cmd_out,
   output logic [DATA_W-1:0] req_data_out,
   input  logic [1:0]        out_resp,
   input  logic [DATA_W-1:0] out_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [1:0]        rsp_code,
   output logic [DATA_W-1:0] rsp_data,
   output logic              busy,
   output logic              protocol_err
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t            state, state_next;
   logic [CNT_W-1:0]  cnt, cnt_next;
   logic [DATA_W-1:0] op2_reg, op2_next;
   logic [CMD_W-1:0]  req_cmd_next;
   logic [DATA_W-1:0] req_data_next;
   logic              rsp_valid_next;
   logic [1:0]        rsp_code_next;
   logic [DATA_W-1:0] rsp_data_next;
   logic              protocol_err_next;

   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         op2_reg      <= '0;
         req_cmd_out  <= '0;
         req_data_out <= '0;
         rsp_valid    <= 1'b0;
         rsp_code     <= RSP_NONE;
         rsp_data     <= '0;
         busy         <= 1'b0;
         txn_ready    <= 1'b1;
         protocol_err <= 1'b0;
      end else begin
         state        <= state_next;
         cnt          <= cnt_next;
         op2_reg      <= op2_next;
         req_cmd_out  <= req_cmd_next;
         req_data_out <= req_data_next;
         rsp_valid    <= rsp_valid_next;
         rsp_code     <= rsp_code_next;
         rsp_data     <= rsp_data_next;
         busy         <= (state_next != ST_IDLE);
         txn_ready    <= (state_next == ST_IDLE);
         protocol_err <= protocol_err_next;
      end
   end

   // Bus registers are loaded from the next-state decision so the bus tracks the state with no extra cycle.
   always_comb begin
      state_next        = state;
      cnt_next          = cnt;
      op2_next          = op2_reg;
      req_cmd_next      = '0;
      req_data_next     = '0;
      rsp_valid_next    = rsp_valid;
      rsp_code_next     = rsp_code;
      rsp_data_next     = rsp_data;
      protocol_err_next = protocol_err | ((state != ST_WAIT_RSP) && (out_resp != RSP_NONE));

      case (state)
         ST_IDLE: begin
            if (txn_valid) begin
               op2_next = txn_op2;
               if (txn_cmd != '0) begin
                  state_next    = ST_SEND_OP1;
                  req_cmd_next  = txn_cmd;
                  req_data_next = txn_op1;
               end else begin
                  state_next     = ST_HOLD_RSP;
                  rsp_valid_next = 1'b1;
                  rsp_code_next  = RSP_NONE;
                  rsp_data_next  = '0;
               end
            end
         end
         ST_SEND_OP1: begin
            state_next    = ST_SEND_OP2;
            req_data_next = op2_reg;
         end
         ST_SEND_OP2: begin
            state_next = ST_WAIT_RSP;
            cnt_next   = '0;
         end
         ST_WAIT_RSP: begin
            // A response on the final counted cycle takes priority over the timeout.
            if (out_resp != RSP_NONE) begin
               state_next     = ST_HOLD_RSP;
               rsp_valid_next = 1'b1;
               rsp_code_next  = out_resp;
               rsp_data_next  = out_data;
            end else if (cnt == CNT_LAST) begin
               state_next     = ST_HOLD_RSP;
               rsp_valid_next = 1'b1;
               rsp_code_next  = RSP_NONE;
               rsp_data_next  = '0;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         ST_HOLD_RSP: begin
            if (rsp_ready) begin
               state_next     = ST_IDLE;
               rsp_valid_next = 1'b0;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_calc_req_driver.sv
// Randomised and directed bench for calc_req_driver; a behavioural calc model supplies the responses.
module tb_calc_req_driver;

   localparam int TO = 8;

   logic        c_clk = 1'b0;
   logic        reset = 1'b0;
   logic        txn_valid = 1'b0;
   logic        txn_ready;
   logic [3:0]  txn_cmd = '0;
   logic [31:0] txn_op1 = '0;
   logic [31:0] txn_op2 = '0;
   logic [3:0]  req_cmd_out;
   logic [31:0] req_data_out;
   logic [1:0]  out_resp = '0;
   logic [31:0] out_data = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [1:0]  rsp_code;
   logic [31:0] rsp_data;
   logic        busy;
   logic        protocol_err;

   int checks = 0;
   int passes = 0;

   calc_req_driver #(.CMD_W(4), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
      .c_clk(c_clk), .reset(reset),
      .txn_valid(txn_valid), .txn_ready(txn_ready),
      .txn_cmd(txn_cmd), .txn_op1(txn_op1), .txn_op2(txn_op2),
      .req_cmd_out(req_cmd_out), .req_data_out(req_data_out),
      .out_resp(out_resp), .out_data(out_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_code(rsp_code), .rsp_data(rsp_data),
      .busy(busy), .protocol_err(protocol_err)
   );

   always #5 c_clk = ~c_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge c_clk);
      #1;
   endtask

   // What an ideal calc returns for a command.
   function automatic void calc_model(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                      output logic [1:0] code, output logic [31:0] data);
      logic [32:0] wide;
      case (cmd)
         4'd1: begin wide = {1'b0, a} + {1'b0, b}; data = wide[31:0]; code = wide[32] ? 2'd2 : 2'd1; end
         4'd2: begin data = a - b; code = (a < b) ? 2'd2 : 2'd1; end
         4'd5: begin data = a << b[4:0]; code = 2'd1; end
         4'd6: begin data = a >> b[4:0]; code = 2'd1; end
         default: begin data = '0; code = 2'd3; end
      endcase
   endfunction

   task automatic send(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
      chk("txn_ready_idle", txn_ready, 1);
      txn_valid = 1'b1; txn_cmd = cmd; txn_op1 = a; txn_op2 = b;
      step();
      txn_valid = 1'b0; txn_cmd = 4'($urandom); txn_op1 = $urandom; txn_op2 = $urandom;
      chk("txn_ready_busy", txn_ready, 0);
      chk("busy", busy, 1);
      if (cmd != 4'd0) begin
         chk("bus_cmd_op1", req_cmd_out, cmd);
         chk("bus_data_op1", req_data_out, a);
         step();
         chk("bus_cmd_op2", req_cmd_out, 0);
         chk("bus_data_op2", req_data_out, b);
         step();
         chk("bus_cmd_wait", req_cmd_out, 0);
         chk("bus_data_wait", req_data_out, 0);
      end else begin
         chk("nop_bus_cmd", req_cmd_out, 0);
         chk("nop_bus_data", req_data_out, 0);
      end
   endtask

   // Called in the first WAIT cycle; injects the response after 'delay' wait cycles (none if delay >= TO).
   task automatic wait_rsp(input int delay, input logic [1:0] code, input logic [31:0] data,
                           output logic [1:0] ec, output logic [31:0] ed);
      for (int i = 0; i < TO; i++) begin
         if (i == delay) begin out_resp = code; out_data = data; end
         step();
         out_resp = 2'd0; out_data = $urandom;
         if (i == delay || i == TO - 1) break;
         chk("no_early_rsp", rsp_valid, 0);
         chk("busy_wait", busy, 1);
      end
      if (delay < TO) begin ec = code; ed = data; end
      else begin ec = 2'd0; ed = 32'd0; end
   endtask

   task automatic finish_rsp(input logic [1:0] ec, input logic [31:0] ed, input int hold);
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_code", rsp_code, ec);
      chk("rsp_data", rsp_data, ed);
      rsp_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
         step();
         chk("hold_valid", rsp_valid, 1);
         chk("hold_code", rsp_code, ec);
         chk("hold_data", rsp_data, ed);
         chk("hold_txn_ready", txn_ready, 0);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("post_hs_valid", rsp_valid, 0);
      chk("post_hs_busy", busy, 0);
      chk("post_hs_ready", txn_ready, 1);
   endtask

   task automatic do_txn(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input int delay, input int hold);
      logic [1:0]  mc, ec;
      logic [31:0] md, ed;
      calc_model(cmd, a, b, mc, md);
      send(cmd, a, b);
      if (cmd != 4'd0) wait_rsp(delay, mc, md, ec, ed);
      else begin ec = 2'd0; ed = 32'd0; end
      finish_rsp(ec, ed, hold);
   endtask

   initial begin
      logic [1:0]  mc, ec;
      logic [31:0] md, ed;
      logic [3:0]  rc;

      // Reset state
      step();
      chk("rst_bus_cmd", req_cmd_out, 0);
      chk("rst_bus_data", req_data_out, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_code", rsp_code, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_perr", protocol_err, 0);
      reset = 1'b1;
      step();
      chk("idle_ready", txn_ready, 1);

      // Directed arithmetic cases
      do_txn(4'd1, 32'h0000_0001, 32'h01FF_FFFF, 2, 0);
      do_txn(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1);
      do_txn(4'd2, 32'hFFFF_FFFF, 32'h0000_0001, 3, 0);
      calc_model(4'd1, 32'h0000_0001, 32'h01FF_FFFF, mc, md);
      chk("model_add_sanity", md, 32'h0200_0000);

      // Timeout, then response on the final wait cycle
      do_txn(4'd5, 32'h1234_5678, 32'd4, 100, 0);
      do_txn(4'd6, 32'h8000_0000, 32'd31, TO - 1, 0);

      // Backpressure with a second offer and an unexpected response during HOLD
      calc_model(4'd1, 32'd5, 32'd7, mc, md);
      send(4'd1, 32'd5, 32'd7);
      wait_rsp(1, mc, md, ec, ed);
      chk("bp_code", rsp_code, ec);
      txn_valid = 1'b1; txn_cmd = 4'd2; txn_op1 = 32'd50; txn_op2 = 32'd8;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin out_resp = 2'd1; out_data = 32'hDEAD_BEEF; end
         step();
         out_resp = 2'd0;
         chk("bp_valid", rsp_valid, 1);
         chk("bp_code_stable", rsp_code, ec);
         chk("bp_data_stable", rsp_data, ed);
         chk("bp_txn_ready", txn_ready, 0);
         chk("bp_bus_quiet", req_cmd_out, 0);
      end
      chk("perr_set", protocol_err, 1);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("b2b_bubble_bus", req_cmd_out, 0);
      chk("b2b_bubble_ready", txn_ready, 1);
      calc_model(4'd2, 32'd50, 32'd8, mc, md);
      send(4'd2, 32'd50, 32'd8);
      wait_rsp(0, mc, md, ec, ed);
      finish_rsp(ec, ed, 0);
      chk("perr_sticky", protocol_err, 1);

      // No-op
      do_txn(4'd0, 32'hAAAA_AAAA, 32'h5555_5555, 0, 2);

      // Reset while the first operand is on the bus
      chk("op1_ready", txn_ready, 1);
      txn_valid = 1'b1; txn_cmd = 4'd1; txn_op1 = 32'hCAFE_0001; txn_op2 = 32'd2;
      step();
      txn_valid = 1'b0;
      chk("pre_rst_bus", req_data_out, 32'hCAFE_0001);
      #2 reset = 1'b0;
      #1;
      chk("arst_bus_cmd", req_cmd_out, 0);
      chk("arst_bus_data", req_data_out, 0);
      chk("arst_busy", busy, 0);
      chk("arst_perr", protocol_err, 0);
      step();
      reset = 1'b1;
      step();
      chk("arst_idle_ready", txn_ready, 1);

      // Reset during WAIT_RSP with a stale response presented while in reset
      send(4'd1, 32'd3, 32'd4);
      step();
      #2 reset = 1'b0;
      out_resp = 2'd1; out_data = 32'h0BAD_0BAD;
      #1;
      chk("wrst_busy", busy, 0);
      chk("wrst_valid", rsp_valid, 0);
      chk("wrst_code", rsp_code, 0);
      chk("wrst_data", rsp_data, 0);
      step();
      out_resp = 2'd0;
      reset = 1'b1;
      step();
      chk("wrst_no_stale", rsp_valid, 0);
      chk("wrst_ready", txn_ready, 1);
      chk("wrst_perr", protocol_err, 0);

      // Randomised transactions
      for (int n = 0; n < 24; n++) begin
         case ($urandom_range(0, 5))
            0: rc = 4'd0;
            1: rc = 4'd1;
            2: rc = 4'd2;
            3: rc = 4'd5;
            4: rc = 4'd6;
            default: rc = 4'($urandom);
         endcase
         do_txn(rc, $urandom, $urandom, $urandom_range(0, TO + 1), $urandom_range(0, 2));
      end
      chk("final_perr", protocol_err, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
